// File: rtl/pipeline_wb_skid.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pipeline_wb_skid                                             |
// | Brief   : Two-entry skid buffer in front of writeback, with flush and  |
// |           age-based selective squash.                                  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pipeline_wb_skid #(
  parameter int DATA_WIDTH      = 32,
  parameter int FREE_LIST_WIDTH = 3,
  parameter int VREG_WIDTH      = 5,
  parameter int PREG_WIDTH      = 6,
  parameter int CP0_ADDR_WIDTH  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       global_flush,
  input  logic                       kill_valid,
  input  logic [FREE_LIST_WIDTH-1:0] kill_index,
  input  logic [FREE_LIST_WIDTH-1:0] al_head,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       wb_reg_in,
  input  logic                       wb_cp0_in,
  input  logic [DATA_WIDTH-1:0]      reg_write_in,
  input  logic [VREG_WIDTH-1:0]      virtual_write_addr_in,
  input  logic [PREG_WIDTH-1:0]      physical_write_addr_in,
  input  logic [FREE_LIST_WIDTH-1:0] active_list_index_in,
  input  logic [CP0_ADDR_WIDTH-1:0]  cp0_write_addr_in,
  input  logic [DATA_WIDTH-1:0]      cp0_write_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       wb_reg_out,
  output logic                       wb_cp0_out,
  output logic [DATA_WIDTH-1:0]      reg_write_out,
  output logic [VREG_WIDTH-1:0]      virtual_write_addr_out,
  output logic [PREG_WIDTH-1:0]      physical_write_addr_out,
  output logic [FREE_LIST_WIDTH-1:0] active_list_index_out,
  output logic [CP0_ADDR_WIDTH-1:0]  cp0_write_addr_out,
  output logic [DATA_WIDTH-1:0]      cp0_write_out
);

  typedef struct packed {
    logic                       wb_reg;
    logic                       wb_cp0;
    logic [DATA_WIDTH-1:0]      reg_data;
    logic [VREG_WIDTH-1:0]      vaddr;
    logic [PREG_WIDTH-1:0]      paddr;
    logic [FREE_LIST_WIDTH-1:0] tag;
    logic [CP0_ADDR_WIDTH-1:0]  cp0_addr;
    logic [DATA_WIDTH-1:0]      cp0_data;
  } beat_t;

  // Age is the distance from the active-list head, so ordering survives index wrap.
  function automatic logic f_younger(input logic [FREE_LIST_WIDTH-1:0] i_tag,
                                     input logic [FREE_LIST_WIDTH-1:0] i_kill,
                                     input logic [FREE_LIST_WIDTH-1:0] i_head);
    logic [FREE_LIST_WIDTH-1:0] w_age_tag;
    logic [FREE_LIST_WIDTH-1:0] w_age_kill;
    w_age_tag  = i_tag - i_head;
    w_age_kill = i_kill - i_head;
    return w_age_tag > w_age_kill;
  endfunction

  beat_t r_main, r_skid;
  logic  r_main_valid, r_skid_valid, r_in_ready;

  beat_t w_in, w_out, w_main_nx, w_skid_nx;
  logic  w_main_valid_nx, w_skid_valid_nx;
  logic  w_flush, w_accept, w_xfer;
  logic  w_kill_main, w_kill_skid, w_kill_in;
  logic  w_main_live, w_skid_live, w_in_live;

  assign w_in = {wb_reg_in, wb_cp0_in, reg_write_in, virtual_write_addr_in,
                 physical_write_addr_in, active_list_index_in,
                 cp0_write_addr_in, cp0_write_in};

  assign w_flush  = flush || global_flush;
  assign w_accept = in_valid && r_in_ready;
  assign w_xfer   = r_main_valid && out_ready;

  // SKID is always younger than MAIN, so losing MAIN must take SKID with it.
  assign w_kill_main = kill_valid && r_main_valid && f_younger(r_main.tag, kill_index, al_head);
  assign w_kill_skid = kill_valid && r_skid_valid &&
                       (w_kill_main || f_younger(r_skid.tag, kill_index, al_head));
  assign w_kill_in   = kill_valid && f_younger(active_list_index_in, kill_index, al_head);

  assign w_main_live = r_main_valid && !w_kill_main;
  assign w_skid_live = r_skid_valid && !w_kill_skid;
  assign w_in_live   = w_accept && !w_kill_in;

  always_comb begin
    w_main_valid_nx = r_main_valid;
    w_main_nx       = r_main;
    w_skid_valid_nx = w_skid_live;
    w_skid_nx       = r_skid;
    if (w_flush) begin
      w_main_valid_nx = 1'b0;
      w_skid_valid_nx = 1'b0;
    end else if (!w_main_live || w_xfer) begin
      if (w_skid_live) begin
        w_main_valid_nx = 1'b1;
        w_main_nx       = r_skid;
        w_skid_valid_nx = w_in_live;
        w_skid_nx       = w_in;
      end else begin
        w_main_valid_nx = w_in_live;
        w_main_nx       = w_in;
        w_skid_valid_nx = 1'b0;
      end
    end else if (w_in_live) begin
      w_skid_valid_nx = 1'b1;
      w_skid_nx       = w_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main       <= '0;
      r_skid       <= '0;
    end else begin
      r_main_valid <= w_main_valid_nx;
      r_skid_valid <= w_skid_valid_nx;
      r_in_ready   <= !w_skid_valid_nx;
      r_main       <= w_main_nx;
      r_skid       <= w_skid_nx;
    end
  end

  assign w_out = r_main_valid ? r_main : '0;

  assign in_ready                = r_in_ready;
  assign out_valid               = r_main_valid;
  assign wb_reg_out              = w_out.wb_reg;
  assign wb_cp0_out              = w_out.wb_cp0;
  assign reg_write_out           = w_out.reg_data;
  assign virtual_write_addr_out  = w_out.vaddr;
  assign physical_write_addr_out = w_out.paddr;
  assign active_list_index_out   = w_out.tag;
  assign cp0_write_addr_out      = w_out.cp0_addr;
  assign cp0_write_out           = w_out.cp0_data;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_wb_skid.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_pipeline_wb_skid                                          |
// | Brief   : Scoreboard bench for pipeline_wb_skid with an in-order queue |
// |           reference model.                                             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pipeline_wb_skid;

  typedef struct packed {
    logic        wr;
    logic        wc;
    logic [31:0] d;
    logic [4:0]  va;
    logic [5:0]  pa;
    logic [2:0]  tag;
    logic [4:0]  ca;
    logic [31:0] cd;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, global_flush, kill_valid;
  logic [2:0]  kill_index, al_head;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        wb_reg_in, wb_cp0_in, wb_reg_out, wb_cp0_out;
  logic [31:0] reg_write_in, cp0_write_in, reg_write_out, cp0_write_out;
  logic [4:0]  virtual_write_addr_in, virtual_write_addr_out;
  logic [5:0]  physical_write_addr_in, physical_write_addr_out;
  logic [2:0]  active_list_index_in, active_list_index_out;
  logic [4:0]  cp0_write_addr_in, cp0_write_addr_out;

  pipeline_wb_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .global_flush(global_flush),
    .kill_valid(kill_valid), .kill_index(kill_index), .al_head(al_head),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_reg_in(wb_reg_in), .wb_cp0_in(wb_cp0_in), .reg_write_in(reg_write_in),
    .virtual_write_addr_in(virtual_write_addr_in),
    .physical_write_addr_in(physical_write_addr_in),
    .active_list_index_in(active_list_index_in),
    .cp0_write_addr_in(cp0_write_addr_in), .cp0_write_in(cp0_write_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_reg_out(wb_reg_out), .wb_cp0_out(wb_cp0_out), .reg_write_out(reg_write_out),
    .virtual_write_addr_out(virtual_write_addr_out),
    .physical_write_addr_out(physical_write_addr_out),
    .active_list_index_out(active_list_index_out),
    .cp0_write_addr_out(cp0_write_addr_out), .cp0_write_out(cp0_write_out)
  );

  always #5 clk = ~clk;

  beat_t      exp_q[$];
  logic [2:0] next_tag = 3'd0;
  int         n_tests  = 0;
  int         n_fail   = 0;

  function automatic beat_t rand_beat(input logic [2:0] tag);
    beat_t b;
    b.wr  = 1'($urandom);
    b.wc  = 1'($urandom);
    b.d   = $urandom;
    b.va  = 5'($urandom);
    b.pa  = 6'($urandom);
    b.tag = tag;
    b.ca  = 5'($urandom);
    b.cd  = $urandom;
    return b;
  endfunction

  function automatic bit is_younger(input logic [2:0] t, input logic [2:0] k, input logic [2:0] h);
    int at, ak;
    at = (int'(t) - int'(h) + 8) % 8;
    ak = (int'(k) - int'(h) + 8) % 8;
    return at > ak;
  endfunction

  function automatic beat_t dut_out();
    return {wb_reg_out, wb_cp0_out, reg_write_out, virtual_write_addr_out,
            physical_write_addr_out, active_list_index_out, cp0_write_addr_out, cp0_write_out};
  endfunction

  task automatic check_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_beat(input string name, input beat_t got, input beat_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: held beats in exp_q are what the DUT should present, oldest first.
  always @(negedge clk) begin
    #1;
    check_bit("out_valid", out_valid, exp_q.size() > 0);
    check_bit("in_ready", in_ready, exp_q.size() < 2);
    if (out_valid && exp_q.size() > 0) begin
      check_beat("payload", dut_out(), exp_q[0]);
      if (out_ready) void'(exp_q.pop_front());
    end else if (!out_valid) begin
      check_beat("idle_zero", dut_out(), '0);
    end
  end

  // Reference model for one clock edge, applied after the monitor has consumed any transfer.
  task automatic model_edge(input bit acc, input beat_t b, input bit kv, input logic [2:0] ki,
                            input logic [2:0] head, input bit fl);
    bit killed, in_killed;
    killed    = 1'b0;
    in_killed = 1'b0;
    if (fl) begin
      exp_q.delete();
      return;
    end
    if (kv) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (is_younger(exp_q[i].tag, ki, head)) begin
          exp_q.delete(i);
          killed = 1'b1;
        end
      end
      if (acc && is_younger(b.tag, ki, head)) in_killed = 1'b1;
      if (killed || in_killed) next_tag = ki + 3'd1;
    end
    if (acc && !in_killed) begin
      exp_q.push_back(b);
      next_tag = b.tag + 3'd1;
    end
  endtask

  task automatic cycle(input bit v, input bit ordy, input bit kv, input logic [2:0] ki,
                       input logic [2:0] head, input bit fl, input bit gfl);
    beat_t b;
    @(negedge clk);
    b = rand_beat(next_tag);
    {wb_reg_in, wb_cp0_in, reg_write_in, virtual_write_addr_in, physical_write_addr_in,
     active_list_index_in, cp0_write_addr_in, cp0_write_in} = b;
    in_valid     = v;
    out_ready    = ordy;
    kill_valid   = kv;
    kill_index   = ki;
    al_head      = head;
    flush        = fl;
    global_flush = gfl;
    #2;
    model_edge(v && in_ready, b, kv, ki, head, fl || gfl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 3'd0, next_tag, 0, 0);
  endtask

  // Reset pulse lands between edges while both entries are full.
  task automatic reset_pulse();
    beat_t b;
    @(negedge clk);
    in_valid = 0; out_ready = 0; kill_valid = 0; flush = 0; global_flush = 0;
    #3 rst_n = 1'b0;
    #1;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_beat("rst_payload", dut_out(), '0);
    exp_q.delete();
    @(negedge clk);
    b = rand_beat(next_tag);
    {wb_reg_in, wb_cp0_in, reg_write_in, virtual_write_addr_in, physical_write_addr_in,
     active_list_index_in, cp0_write_addr_in, cp0_write_in} = b;
    in_valid = 1; al_head = next_tag;
    #3 rst_n = 1'b1;
    model_edge(in_ready, b, 0, 3'd0, next_tag, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] head, ki;
    rst_n = 1'b0; flush = 0; global_flush = 0; kill_valid = 0; kill_index = 0; al_head = 0;
    in_valid = 0; out_ready = 0;
    {wb_reg_in, wb_cp0_in, reg_write_in, virtual_write_addr_in, physical_write_addr_in,
     active_list_index_in, cp0_write_addr_in, cp0_write_in} = '0;
    #23 rst_n = 1'b1;

    // Streaming: tags 0..7 back to back.
    next_tag = 3'd0;
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 3'd0, 3'd0, 0, 0);
    idle(2);

    // Backpressure: A, B held, C stalled, then drained in order.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 3'd0, next_tag, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 3'd0, next_tag, 0, 0);
    idle(3);

    // Flush and global flush while full and stalled.
    cycle(1, 0, 0, 3'd0, next_tag, 0, 0);
    cycle(1, 0, 0, 3'd0, next_tag, 0, 0);
    cycle(1, 0, 0, 3'd0, next_tag, 1, 0);
    cycle(1, 0, 0, 3'd0, next_tag, 0, 0);
    cycle(1, 0, 0, 3'd0, next_tag, 0, 0);
    cycle(1, 1, 0, 3'd0, next_tag, 0, 1);
    idle(2);

    // Wrap-around kill: head 6, MAIN tag 7, SKID tag 0.
    next_tag = 3'd7;
    cycle(1, 0, 0, 3'd0, 3'd6, 0, 0);
    cycle(1, 0, 0, 3'd0, 3'd6, 0, 0);
    cycle(0, 0, 1, 3'd7, 3'd6, 0, 0);
    idle(2);
    next_tag = 3'd7;
    cycle(1, 0, 0, 3'd0, 3'd6, 0, 0);
    cycle(1, 0, 0, 3'd0, 3'd6, 0, 0);
    cycle(0, 0, 1, 3'd5, 3'd6, 0, 0);
    idle(3);

    // Async reset with both entries full.
    cycle(1, 0, 0, 3'd0, next_tag, 0, 0);
    cycle(1, 0, 0, 3'd0, next_tag, 0, 0);
    reset_pulse();
    idle(3);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      head = (exp_q.size() > 0) ? exp_q[0].tag : next_tag;
      head = head - 3'($urandom_range(0, 1));
      ki   = head + 3'($urandom_range(0, 3));
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 8, ki, head,
            $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3);
    end
    idle(4);

    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_wb_skid.md
PIPELINE_WB_SKID -- requirements
Module: pipeline_wb_skid

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32: register and CP0 write-data width.
- REQ-002 SHALL have parameter FREE_LIST_WIDTH, default 3: active-list index width; index space wraps modulo 2^FREE_LIST_WIDTH.
- REQ-003 SHALL have parameter VREG_WIDTH, default 5: architectural register address width.
- REQ-004 SHALL have parameter PREG_WIDTH, default 6: physical register address width.
- REQ-005 SHALL have parameter CP0_ADDR_WIDTH, default 5: CP0 register address width.
- REQ-006 SHALL have ports:
  - clk  in  1  clock; all state updates on the rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - flush  in  1  local flush; drops all held and incoming beats.
  - global_flush  in  1  exception flush; same effect as flush.
  - kill_valid  in  1  selective squash request.
  - kill_index  in  FREE_LIST_WIDTH  oldest surviving instruction; strictly younger entries are squashed.
  - al_head  in  FREE_LIST_WIDTH  active-list head, the age reference.
  - in_valid  in  1  upstream beat valid.
  - in_ready  out  1  stage can accept a beat.
  - wb_reg_in, wb_cp0_in  in  1 each  write enables.
  - reg_write_in  in  DATA_WIDTH  GPR write data.
  - virtual_write_addr_in  in  VREG_WIDTH  architectural destination.
  - physical_write_addr_in  in  PREG_WIDTH  physical destination.
  - active_list_index_in  in  FREE_LIST_WIDTH  instruction tag.
  - cp0_write_addr_in  in  CP0_ADDR_WIDTH  CP0 destination.
  - cp0_write_in  in  DATA_WIDTH  CP0 write data.
  - out_valid  out  1  downstream beat valid.
  - out_ready  in  1  writeback consumes the beat.
  - *_out  out  one per payload input above, same width  registered payload.

Function
- REQ-007 SHALL hold two entries, MAIN (drives outputs) and SKID, each with a valid bit and a full payload copy.
- REQ-008 SHALL drive in_ready = !skid_valid, as a registered value with no combinational path from out_ready.
- REQ-009 SHALL accept a beat when in_valid && in_ready, and SHALL complete a transfer when out_valid && out_ready.
- REQ-010 SHALL drive out_valid = main_valid.
- REQ-011 SHALL drive every payload output to zero whenever out_valid = 0.
- REQ-012 Normal update, one-cycle latency from input to output:
  - MAIN empty, or transferring: MAIN <- SKID if SKID is valid, else <- the accepted beat, else becomes invalid.
  - In the SKID-valid case, an accepted beat moves into SKID.
  - MAIN valid and stalled (!out_ready): an accepted beat goes to SKID.
- REQ-013 SHALL preserve order: no beat overtakes an older one, no beat is duplicated, and no beat is lost except by flush or kill.
- REQ-014 Age SHALL be computed as (tag - al_head) mod 2^FREE_LIST_WIDTH; an entry is younger than kill_index when its age is strictly greater than the age of kill_index.
- REQ-015 When kill_valid is asserted, each held entry and the incoming beat that is younger than kill_index SHALL be invalidated in that cycle; surviving entries update per REQ-012.
- REQ-016 A killed incoming beat SHALL still be counted as accepted, so in_ready handshake semantics are unchanged.
- REQ-017 Because SKID is always younger than MAIN, a kill of MAIN SHALL also kill SKID; an invalid MAIN with a valid SKID SHALL never occur.
- REQ-018 When flush or global_flush is asserted, both entries SHALL become invalid at the next edge and the incoming beat SHALL be dropped; in_ready = 1 the following cycle.
- REQ-019 Priority SHALL be rst_n > flush/global_flush > kill > normal update.
- REQ-020 A transfer whose out_valid && out_ready is sampled in a flush cycle SHALL count as consumed by writeback.

Reset
- REQ-021 While rst_n = 0: out_valid = 0, in_ready = 1, all payload outputs = 0, both entries invalid, independent of clk.
- REQ-022 Reset asserted mid-transfer SHALL discard both entries; the first accept SHALL occur on the first edge after rst_n rises.

Verification
- REQ-023 Streaming: out_ready = 1, tags 0..7 presented back-to-back -> each appears on out_valid exactly one cycle later, in order; in_ready stays 1.
- REQ-024 Backpressure: out_ready = 0 with three beats A, B, C offered -> A held in MAIN, B in SKID, in_ready = 0, C stalled; then out_ready = 1 -> A, B, C delivered in consecutive cycles.
- REQ-025 Wrap-around kill: al_head = 6, MAIN tag 7, SKID tag 0, kill_index = 7 -> SKID invalidated, MAIN delivered; kill_index = 5 (age 7) -> both survive.
- REQ-026 Flush while full and stalled -> next cycle out_valid = 0, in_ready = 1, payload outputs all zero.
- REQ-027 Async reset pulse between clock edges with both entries full -> outputs immediately at reset values; no stale beat emerges after release.
